// File: rtl/trig_scheduler_pkg.sv
// trig_pkg: shared types, angle constants and the angle-fold helper for trig_scheduler.
// Widths come from `INT_BITS (degrees) and `FLOAT_BITS (results); results are Q2.14 fixed point.
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

package trig_pkg;

  typedef logic signed [`INT_BITS-1:0]   deg_t;
  typedef logic signed [`FLOAT_BITS-1:0] fix_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NORM = 3'd1,
    ST_SIN  = 3'd2,
    ST_COS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam deg_t DEG_90  = deg_t'(90);
  localparam deg_t DEG_180 = deg_t'(180);
  localparam deg_t DEG_360 = deg_t'(360);

  // Folds an angle from [-359, 359] into (-180, 180].
  function automatic deg_t fold_deg(input deg_t a);
    deg_t r;
    r = a;
    if (a > DEG_180) begin
      r = a - DEG_360;
    end else if (a <= -DEG_180) begin
      r = a + DEG_360;
    end
    return r;
  endfunction

endpackage

// File: rtl/trig_scheduler_if.sv
// trig_scheduler_if: requester bus (valid/ready/angle per requester) plus the shared
// response channel. The scheduler uses the slave modport, requesters/consumer the master.
interface trig_scheduler_if
  import trig_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]         req_valid;
  deg_t [NUM_REQ-1:0]         req_angle;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  fix_t                       resp_sin;
  fix_t                       resp_cos;

  modport master (
    output req_valid, req_angle, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sin, resp_cos
  );

  modport slave (
    input  req_valid, req_angle, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sin, resp_cos
  );

endinterface

// File: rtl/trig_scheduler_sin_deg_core.sv
// sin_deg_core: combinational sine of an angle in degrees, input in (-180, 180].
// A radians stage reduces the angle to [0, 90] and scales it to Q2.30 radians; a sine
// stage evaluates the odd Taylor series to x^9 in Horner form and rounds to Q2.14.
module sin_deg_core
  import trig_pkg::*;
(
  input  deg_t deg_i,
  output fix_t sin_o
);

  // pi/180 and the Horner reciprocals, all in Q2.30.
  localparam logic signed [63:0] RAD_PER_DEG = 64'sd18740330;
  localparam logic signed [63:0] ONE_Q30     = 64'sd1073741824;
  localparam logic signed [63:0] INV_6       = 64'sd178956971;
  localparam logic signed [63:0] INV_20      = 64'sd53687091;
  localparam logic signed [63:0] INV_42      = 64'sd25565282;
  localparam logic signed [63:0] INV_72      = 64'sd14913081;

  logic               neg;
  deg_t               mag;
  deg_t               quad;
  logic signed [63:0] rad;
  logic signed [63:0] x2;
  logic signed [63:0] t;
  logic signed [63:0] s;
  logic signed [63:0] s_round;
  fix_t               mag_fix;

  // Radians stage: sin is odd and symmetric about 90, so only [0, 90] is evaluated.
  always_comb begin
    neg  = deg_i[`INT_BITS-1];
    mag  = neg ? -deg_i : deg_i;
    quad = (mag > DEG_90) ? (DEG_180 - mag) : mag;
    rad  = 64'(quad) * RAD_PER_DEG;
  end

  // Sine stage: x*(1 - x^2/6*(1 - x^2/20*(1 - x^2/42*(1 - x^2/72)))), then restore the sign.
  always_comb begin
    x2      = (rad * rad) >>> 30;
    t       = ONE_Q30 - ((x2 * INV_72) >>> 30);
    t       = ONE_Q30 - ((((x2 * t) >>> 30) * INV_42) >>> 30);
    t       = ONE_Q30 - ((((x2 * t) >>> 30) * INV_20) >>> 30);
    t       = ONE_Q30 - ((((x2 * t) >>> 30) * INV_6) >>> 30);
    s       = (rad * t) >>> 30;
    s_round = (s + 64'sd32768) >>> 16;
    mag_fix = `FLOAT_BITS'(s_round);
    sin_o   = neg ? -mag_fix : mag_fix;
  end

endmodule

// File: rtl/trig_scheduler.sv
// trig_scheduler: round-robin arbiter that time-shares one degree-to-sine path to return a
// sin/cos pair per request, tagged with the requester id.
// Optional: define TRIG_SCHED_CACHE_EN for a one-entry result cache that lets a repeated
// normalised angle skip the SIN/COS steps.
module trig_scheduler
  import trig_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  trig_scheduler_if.slave bus
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  deg_t            angle_q, angle_d;
  fix_t            sin_q, sin_d;
  fix_t            cos_q, cos_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  deg_t            angle_norm;
  deg_t            core_deg;
  fix_t            core_sin;

`ifdef TRIG_SCHED_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  deg_t            cache_angle_q, cache_angle_d;
  fix_t            cache_sin_q, cache_sin_d;
  fix_t            cache_cos_q, cache_cos_d;
`endif

  sin_deg_core u_sin_core (
    .deg_i (core_deg),
    .sin_o (core_sin)
  );

  assign angle_norm = fold_deg(angle_q);

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  // NOTE: every variable in an always_comb gets a default first so no path infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Shared sine path input: normalised angle for sin, 90 -/+ a for cos.
  always_comb begin
    core_deg = angle_q;
    if (state_q == ST_COS) begin
      core_deg = angle_q[`INT_BITS-1] ? (DEG_90 + angle_q) : (DEG_90 - angle_q);
    end
  end

  // Next-state and datapath updates for the IDLE/NORM/SIN/COS/RESP sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    angle_d = angle_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
`ifdef TRIG_SCHED_CACHE_EN
    cache_vld_d   = cache_vld_q;
    cache_angle_d = cache_angle_q;
    cache_sin_d   = cache_sin_q;
    cache_cos_d   = cache_cos_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_NORM;
          id_d    = grant_idx;
          angle_d = bus.req_angle[grant_idx];
          ptr_d   = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
        end
      end
      ST_NORM: begin
        angle_d = angle_norm;
        state_d = ST_SIN;
`ifdef TRIG_SCHED_CACHE_EN
        if (cache_vld_q && (cache_angle_q == angle_norm)) begin
          state_d = ST_RESP;
          sin_d   = cache_sin_q;
          cos_d   = cache_cos_q;
        end
`endif
      end
      ST_SIN: begin
        sin_d   = core_sin;
        state_d = ST_COS;
      end
      ST_COS: begin
        cos_d   = core_sin;
        state_d = ST_RESP;
`ifdef TRIG_SCHED_CACHE_EN
        cache_vld_d   = 1'b1;
        cache_angle_d = angle_q;
        cache_sin_d   = sin_q;
        cache_cos_d   = core_sin;
`endif
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: one-hot grant only in IDLE (held low during reset), response from registers.
  always_comb begin
    bus.req_ready = '0;
    if ((state_q == ST_IDLE) && grant_vld && !rst) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_id    = id_q;
    bus.resp_sin   = sin_q;
    bus.resp_cos   = cos_q;
  end

  // State and datapath registers; reset abandons any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      angle_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
`ifdef TRIG_SCHED_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      angle_q <= angle_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
`ifdef TRIG_SCHED_CACHE_EN
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

`ifdef TRIG_SCHED_CACHE_EN
  // Cache payload registers.
  // NOTE: storage qualified by a valid bit needs no reset; only cache_vld_q is reset.
  always_ff @(posedge clk) begin
    cache_angle_q <= cache_angle_d;
    cache_sin_q   <= cache_sin_d;
    cache_cos_q   <= cache_cos_d;
  end
`endif

endmodule

// File: tb/tb_trig_scheduler.sv
// tb_trig_scheduler: directed self-checking bench for trig_scheduler (4 requesters).
// Expected sin/cos come from a real-valued model scaled to Q2.14; latencies and grant
// orders are hand-derived constants. Honours TRIG_SCHED_CACHE_EN for the repeat latency.
`ifndef INT_BITS
`define INT_BITS 16
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

module tb_trig_scheduler;

  localparam int  NUM_REQ = 4;
  localparam int  ID_W    = 2;
  localparam int  TOL     = 2;
  localparam real PI      = 3.14159265358979323846;
`ifdef TRIG_SCHED_CACHE_EN
  localparam int  HIT_LAT = 2;
`else
  localparam int  HIT_LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst;

  trig_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  trig_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic int gold_sin(input int deg);
    return int'($sin(real'(deg) * PI / 180.0) * 16384.0);
  endfunction

  function automatic int gold_cos(input int deg);
    return int'($cos(real'(deg) * PI / 180.0) * 16384.0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for its grant, handshake, then drop valid.
  task automatic issue(input int rid, input int ang);
    int waited;
    waited = 0;
    bus.req_angle[rid] = `INT_BITS'(ang);
    bus.req_valid[rid] = 1'b1;
    #1;
    while (!bus.req_ready[rid] && waited < 60) begin
      tick();
      waited++;
    end
    if (!bus.req_ready[rid]) check($sformatf("grant_timeout_r%0d", rid), 0, 1);
    tick();
    bus.req_valid[rid] = 1'b0;
  endtask

  // Called in the cycle after the handshake; lat counts cycles from the handshake cycle.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(bus.resp_valid), 0);
  endtask

  task automatic run_one(input string tag, input int rid, input int ang, input int exp_lat,
                         output int s, output int c);
    int lat;
    issue(rid, ang);
    wait_resp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_id"}, int'(bus.resp_id), rid);
    s = int'(bus.resp_sin);
    c = int'(bus.resp_cos);
    check({tag, "_sin"}, s, gold_sin(ang), TOL);
    check({tag, "_cos"}, c, gold_cos(ang), TOL);
    consume(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c, s_m1, c_m1, s_a, c_a, lat, bad_data, bad_ready;
    int hold_id, hold_sin, hold_cos;
    int rr_ang [4];

    // Reset state, with a requester already valid to prove the grant stays low.
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_angle  = '0;
    bus.resp_ready = 1'b0;
    bus.req_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  int'(bus.req_ready), 0);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_id",    int'(bus.resp_id), 0);
    check("rst_resp_sin",   int'(bus.resp_sin), 0);
    check("rst_resp_cos",   int'(bus.resp_cos), 0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Reset asserted during SIN abandons the request.
    issue(2, 45);
    tick();
    rst = 1'b1;
    #1;
    check("midsin_resp_valid", int'(bus.resp_valid), 0);
    tick();
    rst = 1'b0;
    bad_data = 0;
    repeat (6) begin
      tick();
      if (bus.resp_valid) bad_data++;
    end
    check("midsin_no_resp", bad_data, 0);

    // Pointer back at 0: requester 1 wins over 3.
    bus.req_angle[3] = `INT_BITS'(270);
    bus.req_valid    = 4'b1010;
    #1;
    check("ptr_reset_grant", int'(bus.req_ready), 4'b0010);
    run_one("r1_a90", 1, 90, 4, s, c);
    check("r1_a90_sin_one", s, 16384, TOL);
    check("r1_a90_cos_zero", c, 0, TOL);
    run_one("r3_a270", 3, 270, 4, s, c);
    check("a270_sin_neg_one", s, -16384, TOL);

    // Sign and wrap cases.
    run_one("r0_am180", 0, -180, 4, s, c);
    check("am180_cos_neg_one", c, -16384, TOL);
    run_one("r1_am1", 1, -1, 4, s_m1, c_m1);
    run_one("r2_a359", 2, 359, HIT_LAT, s, c);
    check("a359_eq_am1_sin", s, s_m1);
    check("a359_eq_am1_cos", c, c_m1);

    // Round-robin with all four requesters continuously valid after a fresh reset.
    rr_ang = '{10, 20, 40, 50};
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_angle[i] = `INT_BITS'(rr_ang[i]);
    bus.req_valid = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      int g, waited;
      g = k % NUM_REQ;
      waited = 0;
      while (bus.req_ready == '0 && waited < 20) begin
        tick();
        waited++;
      end
      check($sformatf("rr_grant%0d", k), int'(bus.req_ready), 1 << g);
      tick();
      wait_resp(lat);
      check($sformatf("rr_id%0d", k), int'(bus.resp_id), g);
      check($sformatf("rr_sin%0d", k), int'(bus.resp_sin), gold_sin(rr_ang[g]), TOL);
      consume($sformatf("rr%0d", k));
    end
    bus.req_valid = '0;
    tick();

    // Backpressure: RESP held 10 cycles with another requester waiting.
    issue(0, 60);
    wait_resp(lat);
    check("bp_lat", lat, 4);
    hold_id  = int'(bus.resp_id);
    hold_sin = int'(bus.resp_sin);
    hold_cos = int'(bus.resp_cos);
    check("bp_sin", hold_sin, gold_sin(60), TOL);
    bus.req_angle[2] = `INT_BITS'(120);
    bus.req_valid[2] = 1'b1;
    bad_data  = 0;
    bad_ready = 0;
    repeat (10) begin
      tick();
      if (!bus.resp_valid || int'(bus.resp_id) != hold_id ||
          int'(bus.resp_sin) != hold_sin || int'(bus.resp_cos) != hold_cos) bad_data++;
      if (bus.req_ready != '0) bad_ready++;
    end
    check("bp_hold_stable", bad_data, 0);
    check("bp_no_grant", bad_ready, 0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("bp_release_valid", int'(bus.resp_valid), 0);
    check("bp_release_grant", int'(bus.req_ready), 4'b0100);
    run_one("r2_a120", 2, 120, 4, s, c);

    // Repeated angle: second request hits the cache when it is built in.
    run_one("c30_first", 1, 30, 4, s_a, c_a);
    run_one("c30_second", 3, 30, HIT_LAT, s, c);
    check("c30_same_sin", s, s_a);
    check("c30_same_cos", c, c_a);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
